// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Covers register id/data widths, the writeback entry layout and the round-robin state.
package reg_wb_arbiter_pkg;

    localparam int REG_AW = 5;
    localparam int REG_DW = 32;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [REG_AW-1:0] id;
        logic [REG_DW-1:0] data;
    } wb_entry_t;

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_sel_t;

endpackage

// File: rtl/wb_fifo.sv
// Small power-of-two FIFO for writeback entries. It also exposes per-slot
// valid flags and ids so the owner can match pending destinations.
module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int EW    = 37,
    parameter int IW    = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [EW-1:0]             push_entry,
    input  logic                      pop,
    output logic [EW-1:0]             head,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0]          ent_valid,
    output logic [DEPTH-1:0][IW-1:0]  ent_id
);

    localparam int LW = $clog2(DEPTH);
    localparam int PW = LW + 1;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] count;
    logic [EW-1:0] mem [DEPTH];
    logic          do_push;
    logic          do_pop;
    logic [LW-1:0] offset;

    // The extra pointer bit separates full (only MSB differs) from empty (equal).
    assign full    = (wr_ptr[LW-1:0] == rd_ptr[LW-1:0]) && (wr_ptr[LW] != rd_ptr[LW]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[LW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which slots hold live data.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[LW-1:0]] <= push_entry;
    end

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        ent_valid = '0;
        ent_id    = '0;
        offset    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset       = LW'(i) - rd_ptr[LW-1:0];
            ent_valid[i] = ({1'b0, offset} < count);
            ent_id[i]    = mem[i][EW-1 -: IW];
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU
// and load/multiply writeback paths, with per-read-port pending-write detection.
module reg_wb_arbiter
    import reg_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = REG_AW,
    parameter int DW    = REG_DW
) (
    input  logic          reg_wb_arb_clk,
    input  logic          reg_wb_arb_rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_id,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_id,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic          wr_sig,
    output logic [AW-1:0] wr_id,
    output logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_id1,
    input  logic [AW-1:0] rd_id2,
    output logic          rd_busy1,
    output logic          rd_busy2,
    output logic          idle
);

    localparam int EW = AW + DW;

    logic                     push0, push1;
    logic                     pop0, pop1;
    logic [EW-1:0]            head0, head1;
    logic                     full0, full1;
    logic                     empty0, empty1;
    logic [DEPTH-1:0]         ent_valid0, ent_valid1;
    logic [DEPTH-1:0][AW-1:0] ent_id0, ent_id1;
    logic [EW-1:0]            win_entry;
    logic [AW-1:0]            win_id;
    logic [DW-1:0]            win_data;
    rr_sel_t                  rr_q, rr_d;

    // Ready comes from pre-edge fullness, so a full FIFO refuses even while popping.
    assign req0_ready = !full0;
    assign req1_ready = !full1;
    assign push0      = req0_valid && req0_ready;
    assign push1      = req1_valid && req1_ready;

    wb_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .IW    (AW)
    ) u_fifo0 (
        .clk        (reg_wb_arb_clk),
        .rst        (reg_wb_arb_rst),
        .push       (push0),
        .push_entry ({req0_id, req0_data}),
        .pop        (pop0),
        .head       (head0),
        .full       (full0),
        .empty      (empty0),
        .ent_valid  (ent_valid0),
        .ent_id     (ent_id0)
    );

    wb_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW),
        .IW    (AW)
    ) u_fifo1 (
        .clk        (reg_wb_arb_clk),
        .rst        (reg_wb_arb_rst),
        .push       (push1),
        .push_entry ({req1_id, req1_data}),
        .pop        (pop1),
        .head       (head1),
        .full       (full1),
        .empty      (empty1),
        .ent_valid  (ent_valid1),
        .ent_id     (ent_id1)
    );

    always_ff @(posedge reg_wb_arb_clk) begin
        if (reg_wb_arb_rst) rr_q <= RR_REQ0;
        else                rr_q <= rr_d;
    end

    // The pointer only advances when both FIFOs contend for the write port.
    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        rr_d = rr_q;
        if (!empty0 && !empty1) begin
            if (rr_q == RR_REQ0) begin
                pop0 = 1'b1;
                rr_d = RR_REQ1;
            end else begin
                pop1 = 1'b1;
                rr_d = RR_REQ0;
            end
        end else if (!empty0) begin
            pop0 = 1'b1;
        end else if (!empty1) begin
            pop1 = 1'b1;
        end
    end

    assign win_entry = pop1 ? head1 : head0;
    assign win_id    = win_entry[EW-1:DW];
    assign win_data  = win_entry[DW-1:0];

    // Register 0 is hard-wired zero, so its entries are consumed without a strobe.
    always_ff @(posedge reg_wb_arb_clk) begin
        if (reg_wb_arb_rst) begin
            wr_sig  <= 1'b0;
            wr_id   <= '0;
            wr_data <= '0;
        end else if (pop0 || pop1) begin
            wr_sig  <= (win_id != AW'(REG_ZERO));
            wr_id   <= win_id;
            wr_data <= win_data;
        end else begin
            wr_sig  <= 1'b0;
        end
    end

    always_comb begin
        rd_busy1 = 1'b0;
        rd_busy2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid0[i] && (ent_id0[i] == rd_id1)) rd_busy1 = 1'b1;
            if (ent_valid0[i] && (ent_id0[i] == rd_id2)) rd_busy2 = 1'b1;
            if (ent_valid1[i] && (ent_id1[i] == rd_id1)) rd_busy1 = 1'b1;
            if (ent_valid1[i] && (ent_id1[i] == rd_id2)) rd_busy2 = 1'b1;
        end
        if (wr_sig && (wr_id == rd_id1)) rd_busy1 = 1'b1;
        if (wr_sig && (wr_id == rd_id2)) rd_busy2 = 1'b1;
        if (rd_id1 == AW'(REG_ZERO)) rd_busy1 = 1'b0;
        if (rd_id2 == AW'(REG_ZERO)) rd_busy2 = 1'b0;
    end

    assign idle = empty0 && empty1 && !wr_sig;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Scoreboard bench for reg_wb_arbiter: directed bursts push hand-ordered
// expected writes; a negedge monitor compares every strobed write.
module tb_reg_wb_arbiter;
    import reg_wb_arbiter_pkg::*;

    localparam int DEPTH = 2;
    localparam int AW    = REG_AW;
    localparam int DW    = REG_DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_id, req1_id;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          wr_sig;
    logic [AW-1:0] wr_id;
    logic [DW-1:0] wr_data;
    logic [AW-1:0] rd_id1, rd_id2;
    logic          rd_busy1, rd_busy2;
    logic          idle;

    always #5 clk = ~clk;

    reg_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .reg_wb_arb_clk (clk),
        .reg_wb_arb_rst (rst),
        .req0_valid     (req0_valid),
        .req0_id        (req0_id),
        .req0_data      (req0_data),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_id        (req1_id),
        .req1_data      (req1_data),
        .req1_ready     (req1_ready),
        .wr_sig         (wr_sig),
        .wr_id          (wr_id),
        .wr_data        (wr_data),
        .rd_id1         (rd_id1),
        .rd_id2         (rd_id2),
        .rd_busy1       (rd_busy1),
        .rd_busy2       (rd_busy2),
        .idle           (idle)
    );

    int        errors = 0;
    int        checks = 0;
    int        accepted = 0;
    int        writes = 0;
    int        refusals1 = 0;
    int        pend0 [32];
    int        pend1 [32];
    wb_entry_t exp_q [$];
    wb_entry_t got;
    wb_entry_t stim0 [8];
    wb_entry_t stim1 [8];
    logic      tb_init = 1'b1;
    logic [DW-1:0] rf [32];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic wb_entry_t ent(input int id);
        wb_entry_t e;
        e.id   = AW'(id);
        e.data = 32'hD000_0000 | DW'(id);
        return e;
    endfunction

    // Register file fed by the DUT write port.
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (wr_sig) begin
            rf[wr_id] <= wr_data;
        end
    end

    // Monitor: scoreboard compare on every strobe, plus the upstream ordering contract.
    always @(negedge clk) begin
        if (wr_sig) begin
            writes++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got id=%0d data=%0h, required no write", wr_id, wr_data);
            end else begin
                got = exp_q.pop_front();
                check("wb_id", 64'(wr_id), 64'(got.id));
                check("wb_data", 64'(wr_data), 64'(got.data));
            end
            if (pend0[wr_id] > 0) pend0[wr_id]--;
            else if (pend1[wr_id] > 0) pend1[wr_id]--;
        end
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                pend0[i] = 0;
                pend1[i] = 0;
            end
        end else begin
            if (req0_valid && req0_ready && req0_id != REG_ZERO) begin
                checks++;
                assert (pend1[req0_id] == 0) else begin
                    errors++;
                    $display("FAIL order_contract0: id %0d pending in fifo1 count %0d, required 0", req0_id, pend1[req0_id]);
                end
                pend0[req0_id]++;
                accepted++;
            end
            if (req1_valid && req1_ready && req1_id != REG_ZERO) begin
                checks++;
                assert (pend0[req1_id] == 0) else begin
                    errors++;
                    $display("FAIL order_contract1: id %0d pending in fifo0 count %0d, required 0", req1_id, pend0[req1_id]);
                end
                pend1[req1_id]++;
                accepted++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input wb_entry_t e);
        logic acc;
        int   t;
        req0_valid = 1'b1;
        req0_id    = e.id;
        req0_data  = e.data;
        acc        = 1'b0;
        t          = 0;
        while (!acc && t < 40) begin
            @(negedge clk);
            acc = req0_ready;
            tick();
            t++;
        end
        req0_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL req0_accept_timeout: got ready=0 for id %0d, required 1", e.id);
        end
    endtask

    task automatic drive1(input wb_entry_t e);
        logic acc;
        int   t;
        req1_valid = 1'b1;
        req1_id    = e.id;
        req1_data  = e.data;
        acc        = 1'b0;
        t          = 0;
        while (!acc && t < 40) begin
            @(negedge clk);
            acc = req1_ready;
            if (!acc) refusals1++;
            tick();
            t++;
        end
        req1_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL req1_accept_timeout: got ready=0 for id %0d, required 1", e.id);
        end
    endtask

    task automatic burst(input int n0, input int n1);
        fork
            begin
                for (int i = 0; i < n0; i++) drive0(stim0[i]);
            end
            begin
                for (int j = 0; j < n1; j++) drive1(stim1[j]);
            end
        join
    endtask

    task automatic drain(input string name);
        int t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            tick();
            t++;
        end
        repeat (2) tick();
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_drain_timeout: got %0d writes outstanding, required 0", name, exp_q.size());
        end
        @(negedge clk);
        check({name, "_idle"}, 64'(idle), 64'd1);
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int order_c [8];
        int order_b [12];
        int acc_snap, wr_snap, ref_snap;
        order_c = '{1, 9, 2, 10, 3, 11, 4, 12};
        order_b = '{1, 17, 2, 18, 3, 19, 4, 20, 5, 21, 6, 22};

        req0_valid = 1'b0; req0_id = '0; req0_data = '0;
        req1_valid = 1'b0; req1_id = '0; req1_data = '0;
        rd_id1 = 5'd5; rd_id2 = 5'd3;
        repeat (3) tick();
        tb_init = 1'b0;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_wr_sig", 64'(wr_sig), 64'd0);
        check("rst_wr_id", 64'(wr_id), 64'd0);
        check("rst_wr_data", 64'(wr_data), 64'd0);
        check("rst_ready0", 64'(req0_ready), 64'd1);
        check("rst_ready1", 64'(req1_ready), 64'd1);
        check("rst_idle", 64'(idle), 64'd1);
        check("rst_busy1", 64'(rd_busy1), 64'd0);
        check("rst_busy2", 64'(rd_busy2), 64'd0);
        repeat (2) tick();
        @(negedge clk);
        check("idle_r5", 64'(rf[5]), 64'd0);
        check("idle_still", 64'(idle), 64'd1);

        // Single write: id 3 accepted at edge 1, strobed in cycle 2, written at edge 3
        tick();
        exp_q.push_back('{id: 5'd3, data: 32'h0000_1234});
        req0_valid = 1'b1; req0_id = 5'd3; req0_data = 32'h0000_1234;
        rd_id1 = 5'd3; rd_id2 = 5'd3;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("single_c1_busy1", 64'(rd_busy1), 64'd1);
        check("single_c1_busy2", 64'(rd_busy2), 64'd1);
        check("single_c1_wr_sig", 64'(wr_sig), 64'd0);
        check("single_c1_idle", 64'(idle), 64'd0);
        tick();
        @(negedge clk);
        check("single_c2_wr_sig", 64'(wr_sig), 64'd1);
        check("single_c2_wr_id", 64'(wr_id), 64'd3);
        check("single_c2_wr_data", 64'(wr_data), 64'h1234);
        check("single_c2_busy1", 64'(rd_busy1), 64'd1);
        tick();
        @(negedge clk);
        check("single_c3_rf3", 64'(rf[3]), 64'h1234);
        check("single_c3_busy1", 64'(rd_busy1), 64'd0);
        check("single_c3_wr_sig", 64'(wr_sig), 64'd0);
        check("single_c3_idle", 64'(idle), 64'd1);

        // Register-zero request is consumed without a strobe
        tick();
        req0_valid = 1'b1; req0_id = REG_ZERO; req0_data = 32'h0000_FFFF;
        rd_id1 = REG_ZERO;
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("zero_queued_idle", 64'(idle), 64'd0);
        check("zero_busy1", 64'(rd_busy1), 64'd0);
        tick();
        @(negedge clk);
        check("zero_wr_sig", 64'(wr_sig), 64'd0);
        check("zero_consumed_idle", 64'(idle), 64'd1);
        check("zero_ready0", 64'(req0_ready), 64'd1);

        // Contention: alternating grants starting at req0
        do_reset();
        for (int i = 0; i < 4; i++) begin
            stim0[i] = ent(i + 1);
            stim1[i] = ent(i + 9);
        end
        for (int i = 0; i < 8; i++) exp_q.push_back(ent(order_c[i]));
        burst(4, 4);
        drain("contention");

        // Backpressure: both saturated, req1 stalls, nothing lost or duplicated
        do_reset();
        acc_snap = accepted;
        wr_snap  = writes;
        ref_snap = refusals1;
        for (int i = 0; i < 6; i++) begin
            stim0[i] = ent(i + 1);
            stim1[i] = ent(i + 17);
        end
        for (int i = 0; i < 12; i++) exp_q.push_back(ent(order_b[i]));
        burst(6, 6);
        drain("backpressure");
        check("bp_req1_stalled", 64'((refusals1 - ref_snap) > 0), 64'd1);
        check("bp_accepted", 64'(accepted - acc_snap), 64'd12);
        check("bp_writes_eq_accepted", 64'(writes - wr_snap), 64'(accepted - acc_snap));

        // Reset mid-operation: only the write already on the port lands
        do_reset();
        tick();
        exp_q.push_back(ent(7));
        req0_valid = 1'b1; req0_id = 5'd7;  req0_data = ent(7).data;
        req1_valid = 1'b1; req1_id = 5'd23; req1_data = ent(23).data;
        tick();
        req0_id = 5'd13; req0_data = ent(13).data;
        req1_id = 5'd24; req1_data = ent(24).data;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd_id1 = 5'd13; rd_id2 = 5'd24;
        @(negedge clk);
        check("mid_rst_idle", 64'(idle), 64'd1);
        check("mid_rst_wr_sig", 64'(wr_sig), 64'd0);
        check("mid_rst_ready0", 64'(req0_ready), 64'd1);
        check("mid_rst_ready1", 64'(req1_ready), 64'd1);
        check("mid_rst_busy1", 64'(rd_busy1), 64'd0);
        check("mid_rst_busy2", 64'(rd_busy2), 64'd0);
        repeat (4) tick();
        @(negedge clk);
        check("mid_rst_rf7", 64'(rf[7]), 64'(ent(7).data));
        check("mid_rst_rf13", 64'(rf[13]), 64'd0);
        check("mid_rst_rf23", 64'(rf[23]), 64'd0);
        check("mid_rst_rf24", 64'(rf[24]), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single register-file write port between two writeback requesters: req0 is the ALU path and req1 is the load/multiply path.
- Each requester has a small FIFO with a valid/ready handshake.
- A round-robin arbiter drains one entry per cycle onto registered write-port outputs that feed the register file (write_sig, write_id, write_data).
- Per-register busy flags let the decode/stall logic detect reads of registers whose writes are still pending.

Parameters:
- DEPTH, 2: entries per requester FIFO; power of two, ≥2.
- AW, 5: register id width.
- DW, 32: data width.

Ports:
- reg_wb_arb_clk  in  1  clock; rising edge.
- reg_wb_arb_rst  in  1  reset; synchronous, active-high.
- req0_valid  in  1  ALU writeback request.
- req0_id  in  AW  ALU destination register.
- req0_data  in  DW  ALU result.
- req0_ready  out  1  FIFO0 can accept; equals !full0.
- req1_valid  in  1  load/mul writeback request.
- req1_id  in  AW  load/mul destination register.
- req1_data  in  DW  load/mul result.
- req1_ready  out  1  FIFO1 can accept; equals !full1.
- wr_sig  out  1  register-file write strobe; registered.
- wr_id  out  AW  register-file write id; registered.
- wr_data  out  DW  register-file write data; registered.
- rd_id1  in  AW  read id being decoded, port 1.
- rd_id2  in  AW  read id being decoded, port 2.
- rd_busy1  out  1  a pending write targets rd_id1; combinational.
- rd_busy2  out  1  a pending write targets rd_id2; combinational.
- idle  out  1  both FIFOs empty and wr_sig=0.

Behaviour:
- Reset (synchronous, active-high):
  - Clears both FIFOs and sets the round-robin pointer to req0.
  - Outputs: wr_sig=0, wr_id=0, wr_data=0.
  - Consequently req0_ready=req1_ready=1, rd_busy1/2=0, idle=1.
  - Reset asserted mid-operation discards all queued entries; no write is issued in the cycle after reset.
- Enqueue: at a rising edge, if reqN_valid && reqN_ready, push {id, data} into FIFO N. Inputs are sampled only on that edge.
- Dequeue and grant, evaluated each edge on the FIFO heads:
  - Neither FIFO non-empty: wr_sig<=0; wr_id/wr_data hold their values.
  - Exactly one non-empty: pop it.
  - Both non-empty: pop the FIFO named by the rr pointer, then set the pointer to the other FIFO.
  - The pointer changes only when both FIFOs were contending.
  - A popped entry loads wr_id/wr_data; wr_sig<=1 iff id!=0. An id-0 entry is consumed silently, because register 0 is hard-wired zero.
- Latency:
  - Request accepted at edge N.
  - With an empty FIFO and no contention, it is popped at edge N+1 and wr_sig is high during cycle N+1.
  - The register file writes at edge N+2.
  - Throughput is one write per cycle in total.
- Simultaneous push and pop on a full FIFO:
  - ready is derived from pre-edge full state, so a full FIFO refuses the push even if it pops that edge.
  - No push can be lost, at the cost of one bubble.
- FIFO pointers are (log2 DEPTH)+1 bits with wrap-around.
  - full: write and read pointers differ only in the MSB.
  - empty: pointers are equal.
- Busy:
  - rd_busyK=1 iff rd_idK!=0 and rd_idK matches any valid FIFO entry in either FIFO, or matches wr_id while wr_sig=1.
  - rd_busyK is cleared after the edge at which the register file performs the write.
- Ordering contract for upstream stall logic:
  - Upstream must not enqueue a destination while the same nonzero id is pending in the other FIFO.
  - Within one FIFO, order is preserved.
  - The bench checks this contract with an assertion.

Decomposition:
- Shared package holds:
  - REG_AW=5 and REG_DW=32.
  - REG_ZERO=5'd0.
  - The typedef of the {id, data} writeback entry.
- One sub-module is natural: wb_fifo, parameterised on DEPTH and entry width, instantiated twice. It exposes push, pop, head, full, empty, and a per-entry valid/id vector for busy matching.
- Arbitration and busy compare logic stay in the top module.

Test Plan:
- Reset, then idle: wr_sig=0, both ready=1, idle=1. Register file r5 stays at its prior value.
- Single write: req0 {id=3, data=0x1234} at edge 1.
  - Cycle 2: wr_sig=1, wr_id=3, wr_data=0x1234, rd_busy1=1 with rd_id1=3.
  - Cycle 3: register file r3=0x1234, rd_busy1=0.
- Contention: req0 and req1 both valid for 4 cycles with ids 1,2,3,4 and 9,10,11,12.
  - Writes alternate 1,9,2,10,3,11,4,12.
  - The pointer starts at req0.
- Backpressure: req1 valid every cycle while req0 is also saturated; with DEPTH=2, req1_ready drops to 0.
  - No entry is lost or duplicated.
  - Count of writes equals count of accepted requests.
- Register-zero request: req0 {id=0, data=0xFFFF}.
  - wr_sig stays 0.
  - Entry is consumed; FIFO empty next cycle.
  - rd_busy1=0 for rd_id1=0.
- Reset mid-operation: fill both FIFOs, assert reset for 1 cycle.
  - Next cycle: idle=1, wr_sig=0, both ready=1.
  - None of the queued writes reach the register file.
